// File: rtl/iq_demod_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel IQ demodulator.
package iq_demod_pkg;

  // Wide enough for the largest supported carrier LUT (64 entries).
  localparam int unsigned MaxPhaseBits = 6;
  typedef logic [MaxPhaseBits-1:0] phase_t;

  localparam real Pi = 3.14159265358979323846;

  // Carrier coefficient k of a depth-entry table: cos when is_msin=0, -sin otherwise.
  // Values at or below -Cmax map to the full negative code.
  function automatic int coeff_val(int k, int depth, int coeff_bits, bit is_msin);
    real cmax;
    real ang;
    real r;
    int  v;
    cmax = real'((1 << (coeff_bits - 1)) - 1);
    ang  = 2.0 * Pi * real'(k) / real'(depth);
    r    = is_msin ? -cmax * $sin(ang) : cmax * $cos(ang);
    v    = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    if (v <= -((1 << (coeff_bits - 1)) - 1)) begin
      v = -(1 << (coeff_bits - 1));
    end
    return v;
  endfunction

  // Round half up by 2^sh, then clamp to a signed out_bits range.
  function automatic longint round_sat(longint p, int unsigned sh, int unsigned out_bits);
    longint r;
    longint hi;
    longint lo;
    r  = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    hi = (longint'(1) <<< (out_bits - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_demod_channel_dp.sv
// One channel of the demodulator datapath: S1 multiply by the carrier, S2 round/saturate.
module iq_demod_channel_dp
  import iq_demod_pkg::*;
#(
  parameter int unsigned DataBits  = 10,
  parameter int unsigned CoeffBits = 16,
  parameter int unsigned OutBits   = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        en_i,
  input  logic signed [DataBits-1:0]  x_i,
  input  logic signed [CoeffBits-1:0] cos_i,
  input  logic signed [CoeffBits-1:0] msin_i,
  output logic signed [OutBits-1:0]   i_o,
  output logic signed [OutBits-1:0]   q_o
);

  localparam int unsigned ProdBits = DataBits + CoeffBits;
  localparam int unsigned Sh       = ProdBits - 1 - OutBits;

  logic signed [ProdBits-1:0] prod_i_d, prod_i_q;
  logic signed [ProdBits-1:0] prod_q_d, prod_q_q;
  logic signed [OutBits-1:0]  i_d, i_q;
  logic signed [OutBits-1:0]  q_d, q_q;

  always_comb begin
    prod_i_d = ProdBits'(x_i) * ProdBits'(cos_i);
    prod_q_d = ProdBits'(x_i) * ProdBits'(msin_i);
    i_d      = OutBits'(round_sat(longint'(prod_i_q), Sh, OutBits));
    q_d      = OutBits'(round_sat(longint'(prod_q_q), Sh, OutBits));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_i_q <= '0;
      prod_q_q <= '0;
      i_q      <= '0;
      q_q      <= '0;
    end else if (en_i) begin
      prod_i_q <= prod_i_d;
      prod_q_q <= prod_q_d;
      i_q      <= i_d;
      q_q      <= q_d;
    end
  end

  assign i_o = i_q;
  assign q_o = q_q;

endmodule

// File: rtl/iq_demodulator_mc.sv
// Multi-channel RF->IQ demodulator: shared carrier phase and LUT, per-channel 2-stage datapath.
module iq_demodulator_mc
  import iq_demod_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned DataBits    = 10,
  parameter int unsigned CoeffBits   = 16,
  parameter int unsigned LutDepth    = 4,
  parameter int unsigned OutBits     = 10,
  localparam int unsigned PhBits     = $clog2(LutDepth)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NumChannels*DataBits-1:0] data_i,
  input  logic                           sync_i,
  input  logic                           last_i,
  input  logic [PhBits-1:0]              phase_offset_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NumChannels*OutBits-1:0] i_data_o,
  output logic [NumChannels*OutBits-1:0] q_data_o,
  output logic                           last_o
);

  logic signed [CoeffBits-1:0] cos_lut  [LutDepth];
  logic signed [CoeffBits-1:0] msin_lut [LutDepth];

  for (genvar k = 0; k < LutDepth; k++) begin : g_lut
    localparam int CosVal  = coeff_val(k, LutDepth, CoeffBits, 1'b0);
    localparam int MsinVal = coeff_val(k, LutDepth, CoeffBits, 1'b1);
    assign cos_lut[k]  = CoeffBits'(CosVal);
    assign msin_lut[k] = CoeffBits'(MsinVal);
  end

  logic   en, accept;
  logic   s1_valid_q, s1_last_q, valid_q, last_q;
  phase_t phase_q, phase_d, off_eff, cur_phase;
  logic signed [CoeffBits-1:0] coef_cos, coef_msin;

  // The whole pipeline moves together; a stalled output freezes every stage.
  assign en      = !valid_q || ready_i;
  assign ready_o = en;
  assign accept  = valid_i && en;

  always_comb begin
    off_eff = phase_t'(phase_offset_i);
    if (32'(off_eff) >= LutDepth) begin
      off_eff = '0;
    end
    cur_phase = sync_i ? off_eff : phase_q;
    phase_d   = phase_q;
    if (accept) begin
      phase_d = (32'(cur_phase) == LutDepth - 1) ? '0 : cur_phase + phase_t'(1);
    end
    coef_cos  = cos_lut[cur_phase[PhBits-1:0]];
    coef_msin = msin_lut[cur_phase[PhBits-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (en) begin
        s1_valid_q <= valid_i;
        s1_last_q  <= last_i;
        valid_q    <= s1_valid_q;
        last_q     <= s1_last_q;
      end
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    iq_demod_channel_dp #(
      .DataBits (DataBits),
      .CoeffBits(CoeffBits),
      .OutBits  (OutBits)
    ) u_dp (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (en),
      .x_i   (data_i[c*DataBits +: DataBits]),
      .cos_i (coef_cos),
      .msin_i(coef_msin),
      .i_o   (i_data_o[c*OutBits +: OutBits]),
      .q_o   (q_data_o[c*OutBits +: OutBits])
    );
  end

endmodule

// File: tb/tb_iq_demodulator_mc.sv
// Scoreboard bench: 4-channel/LutDepth=4 main instance plus a 1-channel/LutDepth=5 instance.
module tb_iq_demodulator_mc;

  localparam int NCh = 4;
  localparam int DB  = 10;
  localparam int OB  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_i = 1'b0, sync_i = 1'b0, last_i = 1'b0, ready_i = 1'b1;
  logic [NCh*DB-1:0] data_i = '0;
  logic [1:0]        phase_offset_i = '0;
  logic              ready_o, valid_o, last_o;
  logic [NCh*OB-1:0] i_data_o, q_data_o;

  logic              v5_valid_i = 1'b0, v5_sync_i = 1'b0;
  logic [DB-1:0]     v5_data_i = '0;
  logic [2:0]        v5_off_i = '0;
  logic              v5_ready_o, v5_valid_o, v5_last_o;
  logic [OB-1:0]     v5_i_o, v5_q_o;

  always #5 clk = ~clk;

  iq_demodulator_mc u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .sync_i(sync_i), .last_i(last_i), .phase_offset_i(phase_offset_i), .valid_o(valid_o),
    .ready_i(ready_i), .i_data_o(i_data_o), .q_data_o(q_data_o), .last_o(last_o)
  );

  iq_demodulator_mc #(.NumChannels(1), .LutDepth(5)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v5_valid_i), .ready_o(v5_ready_o), .data_i(v5_data_i),
    .sync_i(v5_sync_i), .last_i(1'b0), .phase_offset_i(v5_off_i), .valid_o(v5_valid_o),
    .ready_i(1'b1), .i_data_o(v5_i_o), .q_data_o(v5_q_o), .last_o(v5_last_o)
  );

  typedef struct packed {
    logic [NCh*OB-1:0] i;
    logic [NCh*OB-1:0] q;
    logic              last;
  } beat_t;

  typedef struct packed {
    logic [OB-1:0] i;
    logic [OB-1:0] q;
  } beat5_t;

  beat_t  exp_q[$];
  beat5_t exp5_q[$];
  int checks = 0;
  int errors = 0;
  int tb_phase = 0;
  int tb_phase5 = 0;

  // Hand-derived carrier tables (Cmax = 32767, -Cmax promoted to -32768).
  int cos4[4]  = '{32767, 0, -32768, 0};
  int msin4[4] = '{0, -32768, 0, 32767};
  int cos5[5]  = '{32767, 10126, -26509, -26509, 10126};
  int msin5[5] = '{0, -31163, -19260, 19260, 31163};

  function automatic int rs(int p);
    int r;
    r = (p + 16384) >>> 15;
    if (r > 511) r = 511;
    if (r < -512) r = -512;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int x[4], input bit sync, input int off, input bit last);
    int    ph;
    int    guard;
    beat_t e;
    @(negedge clk);
    valid_i = 1'b1;
    sync_i = sync;
    phase_offset_i = 2'(off);
    last_i = last;
    for (int k = 0; k < NCh; k++) data_i[k*DB +: DB] = DB'(x[k]);
    #2;
    guard = 0;
    while (!ready_o && guard <= 50) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (guard > 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_o stayed 0 for %0d cycles, required 1", guard);
    end else begin
      ph = sync ? off : tb_phase;
      tb_phase = (ph + 1) % 4;
      for (int k = 0; k < NCh; k++) begin
        e.i[k*OB +: OB] = OB'(rs(x[k] * cos4[ph]));
        e.q[k*OB +: OB] = OB'(rs(x[k] * msin4[ph]));
      end
      e.last = last;
      exp_q.push_back(e);
      @(posedge clk);
    end
    #1;
    valid_i = 1'b0;
    sync_i = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic send5(input int x, input bit sync, input int off);
    int     ph;
    beat5_t e;
    @(negedge clk);
    v5_valid_i = 1'b1;
    v5_sync_i = sync;
    v5_off_i = 3'(off);
    v5_data_i = DB'(x);
    ph = sync ? ((off >= 5) ? 0 : off) : tb_phase5;
    tb_phase5 = (ph + 1) % 5;
    e.i = OB'(rs(x * cos5[ph]));
    e.q = OB'(rs(x * msin5[ph]));
    exp5_q.push_back(e);
    @(posedge clk);
    #1;
    v5_valid_i = 1'b0;
    v5_sync_i = 1'b0;
  endtask

  // Main-instance monitor: compare on every transfer, and check outputs hold while stalled.
  initial begin : monitor
    bit    stalled;
    beat_t snap;
    beat_t e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (!valid_o || {i_data_o, q_data_o, last_o} !== snap) begin
            errors++;
            $display("FAIL stall_hold: valid=%b i=%h q=%h last=%b, held i=%h q=%h last=%b",
                     valid_o, i_data_o, q_data_o, last_o, snap.i, snap.q, snap.last);
          end
        end
        if (valid_o && ready_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: i=%h q=%h with empty scoreboard", i_data_o, q_data_o);
          end else begin
            e = exp_q.pop_front();
            if ({i_data_o, q_data_o, last_o} !== e) begin
              errors++;
              $display("FAIL beat: i=%h q=%h last=%b expected i=%h q=%h last=%b",
                       i_data_o, q_data_o, last_o, e.i, e.q, e.last);
            end
          end
        end
        stalled = valid_o && !ready_i;
        snap = {i_data_o, q_data_o, last_o};
      end
    end
  end

  initial begin : monitor5
    beat5_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && v5_valid_o) begin
        checks++;
        if (exp5_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat5: i=%0d q=%0d", $signed(v5_i_o), $signed(v5_q_o));
        end else begin
          e = exp5_q.pop_front();
          if ({v5_i_o, v5_q_o} !== e) begin
            errors++;
            $display("FAIL beat5: i=%0d q=%0d expected i=%0d q=%0d",
                     $signed(v5_i_o), $signed(v5_q_o), $signed(e.i), $signed(e.q));
          end
        end
      end
    end
  end

  initial begin : stim
    #12;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_i_data", i_data_o, 0);
    chk("rst_q_data", q_data_o, 0);
    chk("rst_last_o", last_o, 0);
    chk("rst_ready_o", ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) constant tone, latency of the first beat
    send('{100, 100, 100, 100}, 1'b1, 0, 1'b0);
    chk("lat_t1_valid", valid_o, 0);
    @(posedge clk);
    #1;
    chk("lat_t2_valid", valid_o, 1);
    for (int n = 1; n < 8; n++) send('{100, 100, 100, 100}, 1'b0, 0, 1'b0);

    // 2) full-scale negative input, saturation at phase 2
    send('{-512, -512, -512, -512}, 1'b1, 0, 1'b0);
    send('{-512, -512, -512, -512}, 1'b1, 2, 1'b0);

    // 3) downstream stall for 3 cycles while streaming
    fork
      for (int n = 0; n < 6; n++) send('{10 * (n + 1), -20, 37, 300 - n}, 1'b0, 0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        ready_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
          #2;
          chk("stall_ready_o", ready_o, 0);
          @(negedge clk);
        end
        ready_i = 1'b1;
      end
    join

    // 4) mid-stream resync
    send('{100, 100, 100, 100}, 1'b0, 0, 1'b0);
    send('{100, 100, 100, 100}, 1'b1, 2, 1'b0);
    send('{100, 100, 100, 100}, 1'b0, 0, 1'b0);
    send('{100, 100, 100, 100}, 1'b1, 3, 1'b0);

    // 5) mixed channels with bubbles, last_i tagging
    send('{100, -100, 0, 511}, 1'b1, 0, 1'b0);
    repeat (2) @(negedge clk);
    send('{100, -100, 0, 511}, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    send('{100, -100, 0, 511}, 1'b0, 0, 1'b0);
    send('{100, -100, 0, 511}, 1'b0, 0, 1'b1);
    send('{-100, 100, 511, 0}, 1'b0, 0, 1'b0);

    // non-power-of-two LUT: out-of-range offsets clamp to 0, wrap at 4 -> 0
    send5(100, 1'b1, 5);
    send5(100, 1'b0, 0);
    send5(100, 1'b1, 2);
    send5(100, 1'b0, 0);
    send5(100, 1'b0, 0);
    send5(100, 1'b0, 0);
    send5(100, 1'b1, 7);
    send5(-512, 1'b1, 2);

    for (int n = 0; n < 100 && (exp_q.size() != 0 || exp5_q.size() != 0); n++) @(negedge clk);
    chk("drain_main", exp_q.size(), 0);
    chk("drain_lut5", exp5_q.size(), 0);

    // 6) asynchronous reset mid-stream
    send('{50, 50, 50, 50}, 1'b0, 0, 1'b0);
    send('{60, 60, 60, 60}, 1'b0, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_i", i_data_o, 0);
    chk("async_rst_ready", ready_o, 1);
    exp_q.delete();
    exp5_q.delete();
    tb_phase = 0;
    tb_phase5 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send('{100, 100, 100, 100}, 1'b0, 0, 1'b0);
    send('{100, 100, 100, 100}, 1'b0, 0, 1'b1);

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_after_rst", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
